overlay_plotter: RTL

//   Consumer for the 2700-bit game-over overlay bitmap (27 rows x 100 cols, one bit per pixel).

---
 rtl/overlay_plotter.sv | 119 +++++++++++
 1 files changed

// File: rtl/overlay_plotter.sv
// Scans a snapshot of the 27x100 game-over overlay bitmap out as VGA plot requests, one pixel/clock.
// Build option OVERLAY_TRANSPARENT_EN: skip plotting bit=0 pixels so the board shows through.
module overlay_plotter #(
  parameter int unsigned COLS      = 100,
  parameter int unsigned ROWS      = 27,
  parameter int unsigned X_ORIGIN  = 30,
  parameter int unsigned Y_ORIGIN  = 40,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COLS*ROWS-1:0] bitmap,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot
);

  localparam int unsigned NPix = COLS * ROWS;
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned IdxW = $clog2(NPix);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_t;

  state_t          state_q;
  logic            arm_q;
  logic [NPix-1:0] snap_q;
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;

  logic [IdxW-1:0] bit_idx;
  logic            pix_bit;
  logic [8:0]      x_full;
  logic [7:0]      y_full;
  logic            last_col;
  logic            last_row;

  // Row 0 is drawn at the bottom; within a row the bitmap MSB is the leftmost pixel.
  always_comb begin
    bit_idx  = IdxW'(32'(row_q) * COLS + (COLS - 1) - 32'(col_q));
    pix_bit  = snap_q[bit_idx];
    x_full   = 9'(X_ORIGIN) + 9'(col_q);
    y_full   = 8'(Y_ORIGIN) + 8'(ROWS - 1) - 8'(row_q);
    last_col = (col_q == ColW'(COLS - 1));
    last_row = (row_q == RowW'(ROWS - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      arm_q   <= 1'b0;
      snap_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
    end else begin
      done <= 1'b0;
      plot <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // arm_q spends one cycle between snapshot capture and DRAW entry.
          if (arm_q) begin
            arm_q   <= 1'b0;
            state_q <= StDraw;
            busy    <= 1'b1;
          end else if (start) begin
            snap_q <= bitmap;
            arm_q  <= 1'b1;
            col_q  <= '0;
            row_q  <= '0;
          end
        end
        StDraw: begin
`ifdef OVERLAY_TRANSPARENT_EN
          if (pix_bit) begin
            plot   <= 1'b1;
            x      <= 8'(x_full);
            y      <= 7'(y_full);
            colour <= pix_bit ? FG_COLOUR : BG_COLOUR;
          end
`else
          plot   <= 1'b1;
          x      <= 8'(x_full);
          y      <= 7'(y_full);
          colour <= pix_bit ? FG_COLOUR : BG_COLOUR;
`endif
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q   <= '0;
              state_q <= StDone;
              busy    <= 1'b0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
